// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard FSM encodings, control-bundle struct, multiply latency default.
// Pure declarations; no latency, no backpressure.
package pipeline_pkg;

   localparam int MULT_LATENCY_DEF = 4;

   typedef enum logic {
      IDLE      = 1'b0,
      MULT_WAIT = 1'b1
   } hz_state_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic id_ex_bubble;
      logic ex_mem_bubble;
      logic if_id_flush;
      logic mult_done;
   } hz_ctl_t;

   function automatic hz_ctl_t ctl_run();
      hz_ctl_t c;
      c = '0;
      c.pc_write    = 1'b1;
      c.if_id_write = 1'b1;
      c.id_ex_write = 1'b1;
      return c;
   endfunction

   // Whole front end frozen while the multiplier owns EX; EX->MEM gets NOPs.
   function automatic hz_ctl_t ctl_mult_stall();
      hz_ctl_t c;
      c = '0;
      c.ex_mem_bubble = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle between pipeline datapath (master) and hazard unit (slave).
// Combinational control outputs, no backpressure.
interface hazard_stall_unit_if;
   logic [4:0]  rs1_IF_ID;
   logic [4:0]  rs2_IF_ID;
   logic [4:0]  rd_ID_EX;
   logic        mem_read_ID_EX;
   logic        mult_ID_EX;
   logic        branch_taken_EX;
   logic        pc_write;
   logic        if_id_write;
   logic        id_ex_write;
   logic        id_ex_bubble;
   logic        ex_mem_bubble;
   logic        if_id_flush;
   logic        mult_done;
   logic [15:0] stall_cycles;

   modport master (
      output rs1_IF_ID, rs2_IF_ID, rd_ID_EX, mem_read_ID_EX, mult_ID_EX, branch_taken_EX,
      input  pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble,
             if_id_flush, mult_done, stall_cycles
   );

   modport slave (
      input  rs1_IF_ID, rs2_IF_ID, rd_ID_EX, mem_read_ID_EX, mult_ID_EX, branch_taken_EX,
      output pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble,
             if_id_flush, mult_done, stall_cycles
   );
endinterface

// File: rtl/mult_latency_counter.sv
// Down-counter tracking remaining multiply stall cycles; load wins over decrement.
// Outputs are the registered count, valid the cycle after load; no backpressure.
module mult_latency_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_value;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign value = cnt;
   assign zero  = (cnt == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: multi-cycle multiply stall, load-use stall, taken-branch flush.
// Control outputs combinational from state and inputs; a multiply holds the front end MULT_LATENCY-1 cycles.
module hazard_stall_unit
   import pipeline_pkg::*;
#(
   parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
   input  logic                 clk,
   input  logic                 arst,
   hazard_stall_unit_if.slave   hz
);

   localparam int CNT_W = $clog2(MULT_LATENCY);

   hz_state_t  state;
   hz_state_t  state_nxt;
   hz_ctl_t    ctl;
   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_zero;
   logic [CNT_W-1:0] cnt_value;
   logic       load_use;
   logic [15:0] stall_cnt;

   assign load_use = hz.mem_read_ID_EX && (hz.rd_ID_EX != 5'd0) &&
                     ((hz.rd_ID_EX == hz.rs1_IF_ID) || (hz.rd_ID_EX == hz.rs2_IF_ID));

   mult_latency_counter #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .arst       (arst),
      .load       (cnt_load),
      .dec        (cnt_dec),
      .load_value (CNT_W'(MULT_LATENCY - 2)),
      .zero       (cnt_zero),
      .value      (cnt_value)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Priority in IDLE: multiply, then branch flush, then load-use.
   always_comb begin
      state_nxt = state;
      ctl       = ctl_run();
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      case (state)
         IDLE: begin
            if (hz.mult_ID_EX) begin
               ctl       = ctl_mult_stall();
               cnt_load  = 1'b1;
               state_nxt = MULT_WAIT;
            end else if (hz.branch_taken_EX) begin
               ctl.if_id_flush  = 1'b1;
               ctl.id_ex_bubble = 1'b1;
            end else if (load_use) begin
               ctl.pc_write     = 1'b0;
               ctl.if_id_write  = 1'b0;
               ctl.id_ex_bubble = 1'b1;
            end
         end
         MULT_WAIT: begin
            if (!cnt_zero) begin
               ctl     = ctl_mult_stall();
               cnt_dec = 1'b1;
            end else begin
               ctl.mult_done = 1'b1;
               state_nxt     = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         stall_cnt <= '0;
      end else if (!ctl.pc_write && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign hz.pc_write      = ctl.pc_write;
   assign hz.if_id_write   = ctl.if_id_write;
   assign hz.id_ex_write   = ctl.id_ex_write;
   assign hz.id_ex_bubble  = ctl.id_ex_bubble;
   assign hz.ex_mem_bubble = ctl.ex_mem_bubble;
   assign hz.if_id_flush   = ctl.if_id_flush;
   assign hz.mult_done     = ctl.mult_done;
   assign hz.stall_cycles  = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit at MULT_LATENCY 4 and 2, driven in lockstep.
// Outputs compared each cycle against a cycles-remaining reference model.
module tb_hazard_stall_unit;

   logic clk = 1'b0;
   logic arst = 1'b1;
   always #5 clk = ~clk;

   hazard_stall_unit_if if4 ();
   hazard_stall_unit_if if2 ();

   hazard_stall_unit #(.MULT_LATENCY(4)) u_dut4 (.clk(clk), .arst(arst), .hz(if4));
   hazard_stall_unit #(.MULT_LATENCY(2)) u_dut2 (.clk(clk), .arst(arst), .hz(if2));

   int n_checks = 0;
   int n_errors = 0;

   int left4 = 0, left2 = 0;
   int stalls4 = 0, stalls2 = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Vector order: {pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, mult_done}
   function automatic logic [6:0] model_ctl(input int left, input int lat, input bit mr, input bit mu,
                                           input bit br, input logic [4:0] r1, input logic [4:0] r2,
                                           input logic [4:0] rd, output int left_nxt);
      left_nxt = 0;
      if (left > 0) begin
         left_nxt = left - 1;
         if (left == 1) return 7'b111_0001;
         return 7'b000_0100;
      end
      if (mu) begin
         left_nxt = lat - 1;
         return 7'b000_0100;
      end
      if (br) return 7'b111_1010;
      if (mr && rd != 0 && (rd == r1 || rd == r2)) return 7'b001_1000;
      return 7'b111_0000;
   endfunction

   task automatic step(input bit do_rst, input bit mr, input bit mu, input bit br,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      logic [6:0] e4, e2;
      int nl4, nl2;
      @(negedge clk);
      if4.mem_read_ID_EX = mr; if4.mult_ID_EX = mu; if4.branch_taken_EX = br;
      if4.rs1_IF_ID = r1; if4.rs2_IF_ID = r2; if4.rd_ID_EX = rd;
      if2.mem_read_ID_EX = mr; if2.mult_ID_EX = mu; if2.branch_taken_EX = br;
      if2.rs1_IF_ID = r1; if2.rs2_IF_ID = r2; if2.rd_ID_EX = rd;
      if (do_rst) begin
         arst = 1'b1;
         left4 = 0; left2 = 0; stalls4 = 0; stalls2 = 0;
      end
      #1;
      e4 = model_ctl(left4, 4, mr, mu, br, r1, r2, rd, nl4);
      e2 = model_ctl(left2, 2, mr, mu, br, r1, r2, rd, nl2);
      chk("ctl_L4", 32'({if4.pc_write, if4.if_id_write, if4.id_ex_write, if4.id_ex_bubble,
                         if4.ex_mem_bubble, if4.if_id_flush, if4.mult_done}), 32'(e4));
      chk("stall_cycles_L4", 32'(if4.stall_cycles), 32'(stalls4));
      chk("ctl_L2", 32'({if2.pc_write, if2.if_id_write, if2.id_ex_write, if2.id_ex_bubble,
                         if2.ex_mem_bubble, if2.if_id_flush, if2.mult_done}), 32'(e2));
      chk("stall_cycles_L2", 32'(if2.stall_cycles), 32'(stalls2));
      left4 = nl4;
      left2 = nl2;
      if (!e4[6] && stalls4 < 65535) stalls4++;
      if (!e2[6] && stalls2 < 65535) stalls2++;
      if (do_rst) begin
         #2 arst = 1'b0;
      end
   endtask

   initial begin
      if4.mem_read_ID_EX = 0; if4.mult_ID_EX = 0; if4.branch_taken_EX = 0;
      if4.rs1_IF_ID = 0; if4.rs2_IF_ID = 0; if4.rd_ID_EX = 0;
      if2.mem_read_ID_EX = 0; if2.mult_ID_EX = 0; if2.branch_taken_EX = 0;
      if2.rs1_IF_ID = 0; if2.rs2_IF_ID = 0; if2.rd_ID_EX = 0;

      // Reset state with all inputs low.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // Multiply held high four cycles: L4 stalls 3 then done; L2 stalls 1, done, repeats.
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
      chk("mult_stalls_L4", 32'(if4.stall_cycles), 32'd3);
      step(0, 0, 0, 0, 0, 0, 0);

      // Load-use on rs2, then same with rd=x0, then load-use plus taken branch.
      step(0, 1, 0, 0, 5'd7, 5'd5, 5'd5);
      step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      step(0, 1, 0, 1, 5'd5, 5'd9, 5'd5);
      step(0, 1, 0, 0, 5'd5, 5'd9, 5'd5);

      // Multiply combined with branch and with load: multiply path wins.
      step(0, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 5'd4, 5'd4, 5'd4);
      step(0, 1, 1, 0, 5'd4, 5'd4, 5'd4);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

      // Reset while L4 is in MULT_WAIT with one stall cycle left.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);

      // Saturation: continuous load-use stall past 16'hFFFF.
      for (int i = 0; i < 70000; i++) step(0, 1, 0, 0, 5'd3, 5'd1, 5'd3);
      chk("stall_saturated_L4", 32'(if4.stall_cycles), 32'hFFFF);
      step(1, 0, 0, 0, 0, 0, 0);

      // Random traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 150) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 4) == 0,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
